// File: rtl/sleep_mode_ctrl.sv
// Air cleaner mode sequencer: key decode, fan level, sleep-timer presets and start/expiry.
// Optional buzzer: define BEEP_EN to drive beep for BEEP_CYCLES after each accepted action.
module sleep_mode_ctrl #(
   parameter logic [7:0]  DEF_MIN     = 8'd30,
   parameter logic [7:0]  MIN_STEP    = 8'd10,
   parameter logic [7:0]  MIN_MAX     = 8'd90,
   parameter logic [23:0] BEEP_CYCLES = 24'd5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_power,
   input  logic       key_mode,
   input  logic       key_timer,
   input  logic       key_start,
   input  logic       sleep_flag,
   output logic [7:0] min_counter,
   output logic [7:0] sec_counter,
   output logic       count_begin,
   output logic [1:0] fan_level,
   output logic [2:0] ctrl_state,
   output logic       beep
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_RUN   = 3'd1,
      S_SET   = 3'd2,
      S_COUNT = 3'd3,
      S_SLEEP = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] fan_q, fan_d, saved_q, saved_d;
   logic [7:0] min_q, min_d, sec_q, sec_d;
   logic       cb_q, cb_d;
   logic       evt_d;
   logic [1:0] fan_step;
   logic [7:0] min_sum;

   assign fan_step = (fan_q == 2'd3) ? 2'd1 : fan_q + 2'd1;
   assign min_sum  = min_q + MIN_STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_OFF;
         fan_q   <= 2'd0;
         saved_q <= 2'd1;
         min_q   <= DEF_MIN;
         sec_q   <= 8'd0;
         cb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fan_q   <= fan_d;
         saved_q <= saved_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         cb_q    <= cb_d;
      end
   end

   // The highest pressed key claims the cycle even if this state ignores it.
   always_comb begin
      state_d = state_q;
      fan_d   = fan_q;
      saved_d = saved_q;
      min_d   = min_q;
      sec_d   = sec_q;
      cb_d    = cb_q;
      evt_d   = 1'b0;
      case (state_q)
         S_OFF, S_SLEEP: begin
            fan_d = 2'd0;
            cb_d  = 1'b0;
            if (key_power) begin
               state_d = S_RUN;
               fan_d   = saved_q;
               evt_d   = 1'b1;
            end
         end
         S_RUN, S_SET, S_COUNT: begin
            if (key_power) begin
               state_d = S_OFF;
               fan_d   = 2'd0;
               cb_d    = 1'b0;
               evt_d   = 1'b1;
            end else if (key_start) begin
               if (state_q == S_SET) begin
                  state_d = S_COUNT;
                  cb_d    = 1'b1;
                  evt_d   = 1'b1;
               end
            end else if (key_timer) begin
               evt_d = 1'b1;
               if (state_q == S_RUN) begin
                  state_d = S_SET;
                  min_d   = DEF_MIN;
                  sec_d   = 8'd0;
               end else if (state_q == S_SET) begin
                  min_d = (min_sum > MIN_MAX) ? MIN_STEP : min_sum;
               end else begin
                  state_d = S_RUN;
                  cb_d    = 1'b0;
               end
            end else if (key_mode) begin
               fan_d   = fan_step;
               saved_d = fan_step;
               evt_d   = 1'b1;
            end else if (sleep_flag && state_q == S_COUNT) begin
               state_d = S_SLEEP;
               fan_d   = 2'd0;
               cb_d    = 1'b0;
               evt_d   = 1'b1;
            end
         end
         default: begin
            state_d = S_OFF;
            fan_d   = 2'd0;
            cb_d    = 1'b0;
         end
      endcase
   end

   assign ctrl_state  = state_q;
   assign fan_level   = fan_q;
   assign min_counter = min_q;
   assign sec_counter = sec_q;
   assign count_begin = cb_q;

`ifdef BEEP_EN
   logic [23:0] beep_cnt;
   logic        beep_q;

   // Counter holds remaining length; beep_q stays high while more than one cycle is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_cnt <= 24'd0;
         beep_q   <= 1'b0;
      end else if (evt_d) begin
         beep_cnt <= BEEP_CYCLES;
         beep_q   <= 1'b1;
      end else begin
         if (beep_cnt != 24'd0) beep_cnt <= beep_cnt - 24'd1;
         beep_q <= (beep_cnt > 24'd1);
      end
   end

   assign beep = beep_q;
`else
   wire unused_beep = &{1'b0, BEEP_CYCLES, evt_d};
   assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_sleep_mode_ctrl.sv
// Randomized and directed checks of sleep_mode_ctrl against a key-action reference model.
module tb_sleep_mode_ctrl;
   localparam int BEEP_N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_power = 0, key_mode = 0, key_timer = 0, key_start = 0, sleep_flag = 0;
   logic [7:0] min_counter, sec_counter;
   logic       count_begin, beep;
   logic [1:0] fan_level;
   logic [2:0] ctrl_state;

   int n_tests = 0;
   int n_fail  = 0;

   sleep_mode_ctrl #(.BEEP_CYCLES(24'd4)) dut (
      .clk(clk), .rst_n(rst_n), .key_power(key_power), .key_mode(key_mode),
      .key_timer(key_timer), .key_start(key_start), .sleep_flag(sleep_flag),
      .min_counter(min_counter), .sec_counter(sec_counter), .count_begin(count_begin),
      .fan_level(fan_level), .ctrl_state(ctrl_state), .beep(beep)
   );

   always #5 clk = ~clk;

   // Reference model: states named by their codes, behaviour from the action table.
   logic [2:0] m_state;
   logic [1:0] m_fan, m_saved;
   logic [7:0] m_min, m_sec;
   logic       m_cb;
   int         cyc, last_evt;
   bit         has_evt;

   task automatic mdl_reset();
      m_state = 3'd0; m_fan = 2'd0; m_saved = 2'd1;
      m_min = 8'd30; m_sec = 8'd0; m_cb = 1'b0; has_evt = 0;
   endtask

   task automatic mdl_step(input logic p, m, t, s, f);
      string k;
      bit acc;
      k = p ? "pwr" : s ? "start" : t ? "timer" : m ? "mode" : "none";
      acc = 0;
      if (m_state == 3'd0 || m_state == 3'd4) begin
         if (k == "pwr") begin m_state = 3'd1; m_fan = m_saved; acc = 1; end
      end else if (k == "pwr") begin
         m_state = 3'd0; m_fan = 2'd0; m_cb = 1'b0; acc = 1;
      end else if (k == "mode") begin
         m_fan = 2'((int'(m_fan) % 3) + 1); m_saved = m_fan; acc = 1;
      end else if (k == "timer") begin
         acc = 1;
         if (m_state == 3'd1) begin m_state = 3'd2; m_min = 8'd30; m_sec = 8'd0; end
         else if (m_state == 3'd2) m_min = (int'(m_min) + 10 > 90) ? 8'd10 : m_min + 8'd10;
         else begin m_state = 3'd1; m_cb = 1'b0; end
      end else if (k == "start") begin
         if (m_state == 3'd2) begin m_state = 3'd3; m_cb = 1'b1; acc = 1; end
      end else if (f && m_state == 3'd3) begin
         m_state = 3'd4; m_fan = 2'd0; m_cb = 1'b0; acc = 1;
      end
      if (acc) begin has_evt = 1; last_evt = cyc; end
   endtask

   function automatic logic mdl_beep();
`ifdef BEEP_EN
      return has_evt && (cyc - last_evt) < BEEP_N;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [22:0] mdl_vec();
      return {m_state, m_fan, m_min, m_sec, m_cb, mdl_beep()};
   endfunction

   function automatic logic [22:0] dut_vec();
      return {ctrl_state, fan_level, min_counter, sec_counter, count_begin, beep};
   endfunction

   // One clock with the given inputs; leaves time at posedge+1 for sampling.
   task automatic drive(input logic p, m, t, s, f);
      key_power = p; key_mode = m; key_timer = t; key_start = s; sleep_flag = f;
      @(posedge clk); #1;
      key_power = 0; key_mode = 0; key_timer = 0; key_start = 0; sleep_flag = 0;
      cyc++;
      mdl_step(p, m, t, s, f);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      mdl_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (dut_vec() !== {3'd0, 2'd0, 8'd30, 8'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL reset_values got %h want %h", dut_vec(), {3'd0, 2'd0, 8'd30, 8'd0, 1'b0, 1'b0});
      end
   endtask

   task automatic test_power_mode();
      logic [1:0] exp_fan[3] = '{2'd2, 2'd3, 2'd1};
      do_reset();
      drive(1, 0, 0, 0, 0);
      n_tests++;
      if (ctrl_state !== 3'd1 || fan_level !== 2'd1) begin
         n_fail++; $display("FAIL power_on got st=%0d fan=%0d want st=1 fan=1", ctrl_state, fan_level);
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         n_tests++;
         if (fan_level !== exp_fan[i]) begin
            n_fail++; $display("FAIL mode_step%0d got %0d want %0d", i, fan_level, exp_fan[i]);
         end
      end
   endtask

   task automatic test_timer_preset();
      logic [7:0] exp_min[7] = '{8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd10};
      drive(0, 0, 1, 0, 0);
      n_tests++;
      if (ctrl_state !== 3'd2 || min_counter !== 8'd30 || sec_counter !== 8'd0) begin
         n_fail++; $display("FAIL enter_set got st=%0d min=%0d sec=%0d want 2/30/0", ctrl_state, min_counter, sec_counter);
      end
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 1, 0, 0);
         n_tests++;
         if (min_counter !== exp_min[i]) begin
            n_fail++; $display("FAIL preset_step%0d got %0d want %0d", i, min_counter, exp_min[i]);
         end
      end
   endtask

   task automatic test_sleep();
      do_reset();
      drive(1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0); drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0);
      n_tests++;
      if (ctrl_state !== 3'd3 || count_begin !== 1'b1) begin
         n_fail++; $display("FAIL start_count got st=%0d cb=%0d want 3/1", ctrl_state, count_begin);
      end
      drive(0, 0, 0, 0, 0); drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1);
      n_tests++;
      if (ctrl_state !== 3'd4 || fan_level !== 2'd0 || count_begin !== 1'b0) begin
         n_fail++; $display("FAIL sleep_entry got st=%0d fan=%0d cb=%0d want 4/0/0", ctrl_state, fan_level, count_begin);
      end
      drive(0, 1, 1, 1, 0);
      n_tests++;
      if (ctrl_state !== 3'd4) begin
         n_fail++; $display("FAIL sleep_ignores_keys got st=%0d want 4", ctrl_state);
      end
      drive(1, 0, 0, 0, 0);
      n_tests++;
      if (ctrl_state !== 3'd1 || fan_level !== 2'd3) begin
         n_fail++; $display("FAIL wake got st=%0d fan=%0d want 1/3", ctrl_state, fan_level);
      end
   endtask

   task automatic test_priority();
      drive(1, 1, 0, 0, 0);
      n_tests++;
      if (ctrl_state !== 3'd0 || fan_level !== 2'd0) begin
         n_fail++; $display("FAIL power_beats_mode got st=%0d fan=%0d want 0/0", ctrl_state, fan_level);
      end
      drive(1, 0, 0, 0, 0);
      n_tests++;
      if (fan_level !== 2'd3) begin
         n_fail++; $display("FAIL mode_dropped got fan=%0d want 3", fan_level);
      end
      drive(0, 0, 1, 0, 0); drive(0, 0, 0, 1, 0);
      drive(0, 0, 1, 0, 1);
      n_tests++;
      if (ctrl_state !== 3'd1 || count_begin !== 1'b0) begin
         n_fail++; $display("FAIL key_beats_flag got st=%0d cb=%0d want 1/0", ctrl_state, count_begin);
      end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 1, 0, 0); drive(0, 0, 0, 1, 0);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (dut_vec() !== {3'd0, 2'd0, 8'd30, 8'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL async_reset got %h want %h", dut_vec(), {3'd0, 2'd0, 8'd30, 8'd0, 1'b0, 1'b0});
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      mdl_reset();
   endtask

   task automatic test_beep();
      int hi;
      do_reset();
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
      hi = 0;
      drive(0, 1, 0, 0, 0);
      if (beep) hi++;
      for (int i = 0; i < 7; i++) begin drive(0, 0, 0, 0, 0); if (beep) hi++; end
      n_tests++;
`ifdef BEEP_EN
      if (hi != BEEP_N) begin n_fail++; $display("FAIL beep_len got %0d want %0d", hi, BEEP_N); end
`else
      if (hi != 0) begin n_fail++; $display("FAIL beep_len got %0d want 0", hi); end
`endif
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0);
      hi = 0;
      drive(0, 1, 0, 0, 0);
      if (beep) hi++;
      for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 0); if (beep) hi++; end
      n_tests++;
      if (hi != 0) begin n_fail++; $display("FAIL beep_ignored got %0d want 0", hi); end
   endtask

   task automatic test_random();
      int r, errs;
      logic p, m, t, s, f;
      errs = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         p = (r < 8); s = (r >= 8 && r < 25); t = (r >= 25 && r < 45);
         m = (r >= 45 && r < 65); f = (r >= 65 && r < 80);
         drive(p, m, t, s, f);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin
            n_fail++;
            if (errs++ < 10) $display("FAIL random_step%0d got %h want %h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      cyc = 0; last_evt = 0;
      mdl_reset();
      test_reset();
      test_power_mode();
      test_timer_preset();
      test_sleep();
      test_priority();
      test_async_reset();
      test_beep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
